// File: rtl/im_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them
// to instruction memory from address 0, holding the CPU in reset until the load completes.
module im_boot_loader #(
  parameter int DEPTH_W = 6,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DEPTH_W:0]   len,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               im_we,
  output logic [DEPTH_W-1:0] im_waddr,
  output logic [DATA_W-1:0]  im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [DEPTH_W:0] MAX_LEN_C = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0] ONE_C     = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [DEPTH_W:0] ZERO_C    = {(DEPTH_W+1){1'b0}};

  state_t               state_r, state_s;
  logic [DEPTH_W:0]     len_r, len_s;
  logic [DEPTH_W:0]     word_cnt_r, word_cnt_s;
  logic [1:0]           byte_cnt_r, byte_cnt_s;
  logic [DATA_W-9:0]    asm_r, asm_s;
  logic                 byte_ready_r, byte_ready_s;
  logic                 im_we_r, im_we_s;
  logic [DEPTH_W-1:0]   im_waddr_r, im_waddr_s;
  logic [DATA_W-1:0]    im_wdata_r, im_wdata_s;
  logic                 cpu_hold_r, cpu_hold_s;
  logic                 done_r, done_s;
  logic                 err_r, err_s;
  logic                 len_legal_s;

  assign len_legal_s = (len != ZERO_C) && (len <= MAX_LEN_C);

  // Next-state and next-output logic; every output is computed one cycle ahead and registered.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    word_cnt_s   = word_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    asm_s        = asm_r;
    byte_ready_s = 1'b0;
    im_we_s      = 1'b0;
    im_waddr_s   = im_waddr_r;
    im_wdata_s   = im_wdata_r;
    cpu_hold_s   = cpu_hold_r;
    done_s       = done_r;
    err_s        = err_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (len_legal_s) begin
            state_s      = ST_LOAD;
            len_s        = len;
            word_cnt_s   = ZERO_C;
            byte_cnt_s   = 2'd0;
            byte_ready_s = 1'b1;
            cpu_hold_s   = 1'b1;
            done_s       = 1'b0;
            err_s        = 1'b0;
          end else begin
            // Rejected start leaves state, hold and done untouched.
            err_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        byte_ready_s = 1'b1;
        if (byte_valid && byte_ready_r) begin
          byte_cnt_s = byte_cnt_r + 2'd1;
          case (byte_cnt_r)
            2'd0: asm_s[7:0]   = byte_data;
            2'd1: asm_s[15:8]  = byte_data;
            2'd2: asm_s[23:16] = byte_data;
            2'd3: begin
              im_wdata_s   = {byte_data, asm_r};
              im_waddr_s   = word_cnt_r[DEPTH_W-1:0];
              im_we_s      = 1'b1;
              byte_ready_s = 1'b0;
              state_s      = ST_WRITE;
            end
            default: asm_s = asm_r;
          endcase
        end else begin
          byte_cnt_s = byte_cnt_r;
        end
      end
      ST_WRITE: begin
        word_cnt_s = word_cnt_r + ONE_C;
        if (word_cnt_s == len_r) begin
          state_s    = ST_DONE;
          done_s     = 1'b1;
          cpu_hold_s = 1'b0;
        end else begin
          state_s      = ST_LOAD;
          byte_ready_s = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        cpu_hold_s = 1'b1;
        done_s     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      len_r        <= ZERO_C;
      word_cnt_r   <= ZERO_C;
      byte_cnt_r   <= 2'd0;
      asm_r        <= {(DATA_W-8){1'b0}};
      byte_ready_r <= 1'b0;
      im_we_r      <= 1'b0;
      im_waddr_r   <= {DEPTH_W{1'b0}};
      im_wdata_r   <= {DATA_W{1'b0}};
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      word_cnt_r   <= word_cnt_s;
      byte_cnt_r   <= byte_cnt_s;
      asm_r        <= asm_s;
      byte_ready_r <= byte_ready_s;
      im_we_r      <= im_we_s;
      im_waddr_r   <= im_waddr_s;
      im_wdata_r   <= im_wdata_s;
      cpu_hold_r   <= cpu_hold_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  assign byte_ready = byte_ready_r;
  assign im_we      = im_we_r;
  assign im_waddr   = im_waddr_r;
  assign im_wdata   = im_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule
